// File: rtl/alu_flag_writeback.sv
// rtl/alu_flag_writeback.sv - ALU result capture, C/Z flag registers, conditional register-file writeback
//
// Purpose:
//   Captures one ALU result with its flags and control, resolves ADC/ADZ/NDC/NDZ
//   style conditional execution against the committed C/Z flags, and performs the
//   register-file write through a valid/ready handshake. Squashed instructions
//   leave the register file and flags untouched.
//
// Optional feature macro: SQUASH_CNT_EN (adds sq_count, a wrapping count of squashed retirements)
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   alu_valid / alu_ready      upstream handshake (alu_ready high only in S_IDLE)
//   alu_out, alu_carry, alu_zero, is_nand, condition, dest_reg   captured on accept
//   rf_we / rf_ready           register-file write handshake
//   rf_addr, rf_data           write address/data (capture registers)
//   pc_write                   write targets the PC alias register
//   flag_c, flag_z             committed flags
//   done, squashed, cond_err   retirement pulse and its qualifiers
//   sq_count                   squashed retirement count (SQUASH_CNT_EN only)

module alu_flag_writeback #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int PC_REG = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              is_nand,
  input  logic [1:0]        condition,
  input  logic [REG_AW-1:0] dest_reg,
  output logic              rf_we,
  input  logic              rf_ready,
  output logic [REG_AW-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              pc_write,
  output logic              flag_c,
  output logic              flag_z,
  output logic              done,
  output logic              squashed,
  output logic              cond_err
`ifdef SQUASH_CNT_EN
  ,
  output logic [15:0]       sq_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EVAL  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] cap_data;
  logic [REG_AW-1:0] cap_dest;
  logic              cap_carry;
  logic              cap_zero;
  logic              cap_nand;
  logic              cap_exec;

  // The committed flags cannot change between accept and S_EVAL (they only move
  // on a completed write, which always precedes the next accept), so the execute
  // decision is resolved at accept. That lets the squash pulse be a registered
  // output that is visible during the S_EVAL cycle.
  logic accept_exec;
  always_comb begin
    accept_exec = (condition == 2'b00)
                | ((condition == 2'b01) & flag_z)
                | ((condition == 2'b10) & flag_c);
  end

  assign rf_addr = cap_dest;
  assign rf_data = cap_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      alu_ready <= 1'b1;
      rf_we     <= 1'b0;
      pc_write  <= 1'b0;
      done      <= 1'b0;
      squashed  <= 1'b0;
      cond_err  <= 1'b0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      cap_data  <= '0;
      cap_dest  <= '0;
      cap_carry <= 1'b0;
      cap_zero  <= 1'b0;
      cap_nand  <= 1'b0;
      cap_exec  <= 1'b0;
    end else begin
      done     <= 1'b0;
      squashed <= 1'b0;
      cond_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (alu_valid) begin
            cap_data  <= alu_out;
            cap_dest  <= dest_reg;
            cap_carry <= alu_carry;
            cap_zero  <= alu_zero;
            cap_nand  <= is_nand;
            cap_exec  <= accept_exec;
            alu_ready <= 1'b0;
            state     <= S_EVAL;
            if (!accept_exec) begin
              done     <= 1'b1;
              squashed <= 1'b1;
              cond_err <= (condition == 2'b11);
            end
          end
        end
        S_EVAL: begin
          if (cap_exec) begin
            rf_we    <= 1'b1;
            pc_write <= (cap_dest == REG_AW'(PC_REG));
            state    <= S_WRITE;
          end else begin
            alu_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_WRITE: begin
          if (rf_ready) begin
            flag_z <= cap_zero;
            if (!cap_nand) flag_c <= cap_carry;
            rf_we     <= 1'b0;
            pc_write  <= 1'b0;
            done      <= 1'b1;
            alu_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          rf_we     <= 1'b0;
          pc_write  <= 1'b0;
          alu_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SQUASH_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sq_count <= 16'h0000;
    end else if (done && squashed) begin
      sq_count <= sq_count + 16'h0001;
    end
  end
`endif

endmodule
